// File: rtl/rr_arbiter_4to1.sv
// Round-robin drain of four source FIFOs into one downstream FIFO.
// Pop is combinational off the empty flags; the popped word lands on data_out two cycles later.
module rr_arbiter_4to1 #(
  parameter int DATA_W   = 6,
  parameter int PIPE_DEP = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [3:0]        fifo_empty,
  input  logic [3:0]        fifo_valid,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              down_pause,
  output logic [3:0]        fifo_rd,
  output logic [DATA_W-1:0] data_out,
  output logic              push,
  output logic [1:0]        grant,
  output logic              idle
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

  localparam int            QW      = $clog2(PIPE_DEP + 1);
  localparam logic [QW-1:0] QMAX    = QW'(PIPE_DEP);
  localparam logic [QW-1:0] QMAX_M1 = QW'(PIPE_DEP - 1);

  state_t            state_reg, state_next;
  logic [1:0]        ptr_reg;
  logic              pend_valid_reg;
  logic [1:0]        pend_idx_reg;
  logic              push_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              idle_reg;
  logic [QW-1:0]     quiet_reg;

  logic [1:0]        sel;
  logic [1:0]        idx;
  logic              found;
  logic              pop;
  logic              any_src;
  logic              take;
  logic              idle_next;
  logic [3:0]        vld_hit;
  logic [DATA_W-1:0] src_data [4];

  assign src_data[0] = data_in0;
  assign src_data[1] = data_in1;
  assign src_data[2] = data_in2;
  assign src_data[3] = data_in3;

  // Lowest rotation offset from ptr wins, so scan from the far end down.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_reg + 2'(k);
      if (!fifo_empty[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign pop     = found & ~down_pause & ~RESET;
  assign fifo_rd = pop ? 4'(4'b0001 << sel) : 4'b0000;
  assign grant   = pop ? sel : 2'd0;
  assign any_src = ~&fifo_empty;

  // A returned word is accepted only from the source popped last cycle, alone.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
      assign vld_hit[gi] = pend_valid_reg && (pend_idx_reg == 2'(gi)) &&
                           (fifo_valid == 4'(4'b0001 << gi));
    end
  endgenerate

  assign take = |vld_hit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_src) state_next = down_pause ? ST_HOLD : ST_RUN;
      ST_RUN: begin
        if (down_pause)   state_next = ST_HOLD;
        else if (!any_src) state_next = ST_IDLE;
      end
      ST_HOLD: if (!down_pause) state_next = any_src ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // quiet_reg counts cycles since the last pop; the pipeline is empty once it reaches PIPE_DEP.
  assign idle_next = (state_next == ST_IDLE) && !pop && (quiet_reg >= QMAX_M1);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= '0;
      push_reg       <= 1'b0;
      data_out_reg   <= '0;
      idle_reg       <= 1'b1;
      quiet_reg      <= QMAX;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pop;
      pend_idx_reg   <= sel;
      push_reg       <= take;
      idle_reg       <= idle_next;
      if (pop) ptr_reg <= sel + 2'd1;
      if (take) data_out_reg <= src_data[pend_idx_reg];
      if (pop)                    quiet_reg <= '0;
      else if (quiet_reg != QMAX) quiet_reg <= quiet_reg + 1'b1;
    end
  end

  assign data_out = data_out_reg;
  assign push     = push_reg;
  assign idle     = idle_reg;

endmodule

// File: tb/tb_rr_arbiter_4to1.sv
// Directed bench for rr_arbiter_4to1: behavioural source FIFOs plus per-cycle expected tables.
module tb_rr_arbiter_4to1;

  logic       clk;
  logic       RESET;
  logic [3:0] fifo_empty;
  logic [3:0] fifo_valid = '0;
  logic       down_pause;
  logic [3:0] fifo_rd;
  logic [5:0] data_out;
  logic       push;
  logic [1:0] grant;
  logic       idle;

  logic [5:0] mem [4][16];
  int         wp [4] = '{0, 0, 0, 0};
  int         rp [4] = '{0, 0, 0, 0};
  logic [5:0] din [4] = '{6'd0, 6'd0, 6'd0, 6'd0};

  int vec_cnt = 0;
  int err_cnt = 0;

  rr_arbiter_4to1 #(.DATA_W(6), .PIPE_DEP(2)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .data_in0   (din[0]),
    .data_in1   (din[1]),
    .data_in2   (din[2]),
    .data_in3   (din[3]),
    .down_pause (down_pause),
    .fifo_rd    (fifo_rd),
    .data_out   (data_out),
    .push       (push),
    .grant      (grant),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO model: empty tracks the pointers, valid/data appear the cycle after a pop.
  always_comb begin
    fifo_empty = '0;
    for (int i = 0; i < 4; i++) fifo_empty[i] = (wp[i] == rp[i]);
  end

  always @(posedge clk) begin
    fifo_valid <= fifo_rd;
    for (int i = 0; i < 4; i++) begin
      din[i] <= mem[i][rp[i] % 16];
      if (fifo_rd[i]) rp[i] <= rp[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (push) $display("push data_out=%02h t=%0t", data_out, $time);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int src, input logic [5:0] w);
    mem[src][wp[src] % 16] = w;
    wp[src] = wp[src] + 1;
  endtask

  // One cycle of expectations, then advance to the next negedge.
  task automatic cyc(input string tag, input logic [3:0] erd, input logic epush,
                     input logic [5:0] edata);
    logic [1:0] egr;
    egr = erd[1] ? 2'd1 : erd[2] ? 2'd2 : erd[3] ? 2'd3 : 2'd0;
    check({tag, ".rd"},    32'(fifo_rd),  32'(erd));
    check({tag, ".grant"}, 32'(grant),    32'(egr));
    check({tag, ".push"},  32'(push),     32'(epush));
    check({tag, ".data"},  32'(data_out), 32'(edata));
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RESET      = 1'b1;
    down_pause = 1'b0;

    // Reset with all sources empty.
    repeat (3) begin
      @(negedge clk);
      check("t1.rd",   32'(fifo_rd),  32'h0);
      check("t1.push", 32'(push),     32'h0);
      check("t1.idle", 32'(idle),     32'h1);
      check("t1.data", 32'(data_out), 32'h0);
    end
    RESET = 1'b0;
    @(negedge clk);
    #1;

    // Single source, back-to-back pops.
    load(0, 6'b010010);
    load(0, 6'b100100);
    #1;
    cyc("t2.k0", 4'b0001, 1'b0, 6'b000000);
    cyc("t2.k1", 4'b0001, 1'b0, 6'b000000);
    cyc("t2.k2", 4'b0000, 1'b1, 6'b010010);
    check("t2.idle_busy", 32'(idle), 32'h0);
    cyc("t2.k3", 4'b0000, 1'b1, 6'b100100);
    check("t2.idle_back", 32'(idle), 32'h1);
    cyc("t2.k4", 4'b0000, 1'b0, 6'b100100);

    // All four sources, one word each, pointer back at 0.
    do_reset();
    load(0, 6'h01);
    load(1, 6'h02);
    load(2, 6'h03);
    load(3, 6'h04);
    #1;
    cyc("t3.k0", 4'b0001, 1'b0, 6'h00);
    cyc("t3.k1", 4'b0010, 1'b0, 6'h00);
    cyc("t3.k2", 4'b0100, 1'b1, 6'h01);
    cyc("t3.k3", 4'b1000, 1'b1, 6'h02);
    cyc("t3.k4", 4'b0000, 1'b1, 6'h03);
    cyc("t3.k5", 4'b0000, 1'b1, 6'h04);
    cyc("t3.k6", 4'b0000, 1'b0, 6'h04);

    // Sources 1 and 3 alternate, per-source order preserved.
    load(1, 6'h11); load(1, 6'h12); load(1, 6'h13);
    load(3, 6'h31); load(3, 6'h32); load(3, 6'h33);
    #1;
    cyc("t4.k0", 4'b0010, 1'b0, 6'h04);
    cyc("t4.k1", 4'b1000, 1'b0, 6'h04);
    cyc("t4.k2", 4'b0010, 1'b1, 6'h11);
    cyc("t4.k3", 4'b1000, 1'b1, 6'h31);
    cyc("t4.k4", 4'b0010, 1'b1, 6'h12);
    cyc("t4.k5", 4'b1000, 1'b1, 6'h32);
    cyc("t4.k6", 4'b0000, 1'b1, 6'h13);
    cyc("t4.k7", 4'b0000, 1'b1, 6'h33);
    cyc("t4.k8", 4'b0000, 1'b0, 6'h33);

    // Pause after a pop: in-flight word still pushed, no pops held, pointer kept.
    load(0, 6'h2A); load(0, 6'h2B);
    load(2, 6'h15); load(2, 6'h16);
    #1;
    cyc("t5.k0", 4'b0001, 1'b0, 6'h33);
    down_pause = 1'b1;
    #1;
    cyc("t5.k1", 4'b0000, 1'b0, 6'h33);
    cyc("t5.k2", 4'b0000, 1'b1, 6'h2A);
    check("t5.idle_hold", 32'(idle), 32'h0);
    cyc("t5.k3", 4'b0000, 1'b0, 6'h2A);
    down_pause = 1'b0;
    #1;
    cyc("t5.k4", 4'b0100, 1'b0, 6'h2A);
    cyc("t5.k5", 4'b0001, 1'b0, 6'h2A);
    cyc("t5.k6", 4'b0100, 1'b1, 6'h15);
    cyc("t5.k7", 4'b0000, 1'b1, 6'h2B);
    cyc("t5.k8", 4'b0000, 1'b1, 6'h16);
    cyc("t5.k9", 4'b0000, 1'b0, 6'h16);

    // Reset with words in flight; source 0 served first afterwards.
    load(3, 6'h3C);
    load(0, 6'h0A); load(0, 6'h0B);
    load(1, 6'h21);
    #1;
    cyc("t6.k0", 4'b1000, 1'b0, 6'h16);
    cyc("t6.k1", 4'b0001, 1'b0, 6'h16);
    RESET = 1'b1;
    #1;
    cyc("t6.k2", 4'b0000, 1'b1, 6'h3C);
    check("t6.idle_rst", 32'(idle), 32'h1);
    cyc("t6.k3", 4'b0000, 1'b0, 6'h00);
    RESET = 1'b0;
    #1;
    cyc("t6.k4", 4'b0001, 1'b0, 6'h00);
    cyc("t6.k5", 4'b0010, 1'b0, 6'h00);
    cyc("t6.k6", 4'b0000, 1'b1, 6'h0B);
    cyc("t6.k7", 4'b0000, 1'b1, 6'h21);
    check("t6.idle_end", 32'(idle), 32'h1);
    cyc("t6.k8", 4'b0000, 1'b0, 6'h21);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
